// File: rtl/serial_tx_if.sv
// Push-side bus of the serial transmitter: byte writes in, FIFO occupancy out.
interface serial_tx_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [CW-1:0] count;

  modport master (output wr_en, wr_data, input  full, count);
  modport slave  (input  wr_en, wr_data, output full, count);
endinterface

// File: rtl/serial_tx.sv
// 8N1 byte-serial transmitter fed by a small FIFO; LSB first, CLKDIV clocks per bit.
module serial_tx #(
  parameter int CLKDIV = 4,
  parameter int DEPTH  = 4
) (
  input  logic      clk,
  input  logic      reset,
  serial_tx_if.slave wif,
  output logic      busy,
  output logic      txd
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic          full;
  logic          div_end, push, pop;

  // Push looks only at the registered full flag, so a same-cycle pop never frees room.
  always_comb begin
    div_end   = (div == DIV_LAST);
    push      = wif.wr_en && !full;
    pop       = (count != '0) && ((state == IDLE) || (state == STOP && div_end));
    count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      div     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      full    <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= wif.wr_data;
        wptr      <= wptr + PW'(1);
      end
      if (pop) begin
        shift <= mem[rptr];
        rptr  <= rptr + PW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));

      case (state)
        IDLE: begin
          div <= '0;
          if (pop) begin
            state <= START;
            txd   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (div_end) begin
            div     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            div <= div + DW'(1);
          end
        end
        DATA: begin
          if (div_end) begin
            div <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              // Present the next bit in the same edge that shifts it down.
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        STOP: begin
          if (div_end) begin
            div <= '0;
            if (pop) begin
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wif.full  = full;
  assign wif.count = count;
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at CLKDIV=4/DEPTH=4, one at CLKDIV=1.
module tb_serial_tx;
  logic clk = 1'b0;
  logic reset;
  logic busy_a, txd_a, busy_b, txd_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_tx_if #(.DEPTH(4)) ifa ();
  serial_tx_if #(.DEPTH(4)) ifb ();

  serial_tx #(.CLKDIV(4), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .wif(ifa.slave), .busy(busy_a), .txd(txd_a)
  );
  serial_tx #(.CLKDIV(1), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .wif(ifb.slave), .busy(busy_b), .txd(txd_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk frame cycles k0..k1-1 of byte b: start 0, LSB-first data, stop 1.
  task automatic frame(input string tag, input int sel, input logic [7:0] b,
                       input int cdiv, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      int   bi;
      logic e;
      bi = k / cdiv;
      e  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      chk($sformatf("%s_txd_k%0d", tag, k), 32'(sel ? txd_b : txd_a), 32'(e));
      chk($sformatf("%s_busy_k%0d", tag, k), 32'(sel ? busy_b : busy_a), 32'd1);
      tick();
    end
  endtask

  initial begin
    logic [7:0] ov_cnt [6];
    logic       ov_full [6];
    ov_cnt  = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4};
    ov_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1;
    ifa.wr_en = 1'b0; ifa.wr_data = '0;
    ifb.wr_en = 1'b0; ifb.wr_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_txd_a",   32'(txd_a),     32'd1);
    chk("rst_busy_a",  32'(busy_a),    32'd0);
    chk("rst_count_a", 32'(ifa.count), 32'd0);
    chk("rst_full_a",  32'(ifa.full),  32'd0);
    chk("rst_txd_b",   32'(txd_b),     32'd1);
    chk("rst_busy_b",  32'(busy_b),    32'd0);
    tick();

    // Single byte 0x41
    ifa.wr_en = 1'b1; ifa.wr_data = 8'h41;
    tick();
    ifa.wr_en = 1'b0;
    chk("one_count", 32'(ifa.count), 32'd1);
    chk("one_txd0",  32'(txd_a),     32'd1);
    chk("one_busy0", 32'(busy_a),    32'd0);
    tick();
    chk("one_count_pop", 32'(ifa.count), 32'd0);
    frame("one", 0, 8'h41, 4, 0, 40);
    chk("one_busy_end", 32'(busy_a), 32'd0);
    chk("one_txd_end",  32'(txd_a),  32'd1);
    tick();

    // Overflow: 0x10..0x15 on six edges, last one dropped
    for (int i = 0; i < 6; i++) begin
      ifa.wr_en = 1'b1; ifa.wr_data = 8'h10 + 8'(i);
      tick();
      chk($sformatf("ov_count%0d", i), 32'(ifa.count), 32'(ov_cnt[i]));
      chk($sformatf("ov_full%0d", i),  32'(ifa.full),  32'(ov_full[i]));
    end
    ifa.wr_en = 1'b0;
    frame("ov10", 0, 8'h10, 4, 4, 39);
    // Last STOP cycle while full: push of 0x99 must be dropped
    chk("fp_count_pre", 32'(ifa.count), 32'd4);
    chk("fp_full_pre",  32'(ifa.full),  32'd1);
    ifa.wr_en = 1'b1; ifa.wr_data = 8'h99;
    frame("ov10s", 0, 8'h10, 4, 39, 40);
    ifa.wr_en = 1'b0;
    chk("fp_count_post", 32'(ifa.count), 32'd3);
    chk("fp_full_post",  32'(ifa.full),  32'd0);
    frame("ov11", 0, 8'h11, 4, 0, 40);
    frame("ov12", 0, 8'h12, 4, 0, 40);
    frame("ov13", 0, 8'h13, 4, 0, 40);
    frame("ov14", 0, 8'h14, 4, 0, 40);
    chk("ov_busy_end",  32'(busy_a),    32'd0);
    chk("ov_txd_end",   32'(txd_a),     32'd1);
    chk("ov_count_end", 32'(ifa.count), 32'd0);
    tick();

    // Back-to-back 0xAA, 0x55
    ifa.wr_en = 1'b1; ifa.wr_data = 8'hAA;
    tick();
    chk("b2b_count0", 32'(ifa.count), 32'd1);
    ifa.wr_data = 8'h55;
    tick();
    ifa.wr_en = 1'b0;
    chk("b2b_count1", 32'(ifa.count), 32'd1);
    frame("b2bAA", 0, 8'hAA, 4, 0, 40);
    frame("b2b55", 0, 8'h55, 4, 0, 40);
    chk("b2b_busy_end", 32'(busy_a), 32'd0);
    tick();

    // Reset during DATA bit 3 of 0xF0 with two bytes queued
    ifa.wr_en = 1'b1; ifa.wr_data = 8'hF0;
    tick();
    ifa.wr_data = 8'h11;
    tick();
    ifa.wr_data = 8'h22;
    tick();
    ifa.wr_en = 1'b0;
    chk("rmf_count", 32'(ifa.count), 32'd2);
    frame("rmfF0", 0, 8'hF0, 4, 1, 18);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmf_txd",   32'(txd_a),     32'd1);
    chk("rmf_busy",  32'(busy_a),    32'd0);
    chk("rmf_count0", 32'(ifa.count), 32'd0);
    chk("rmf_full",  32'(ifa.full),  32'd0);
    tick();
    chk("rmf_idle_txd",  32'(txd_a),  32'd1);
    chk("rmf_idle_busy", 32'(busy_a), 32'd0);
    ifa.wr_en = 1'b1; ifa.wr_data = 8'h01;
    tick();
    ifa.wr_en = 1'b0;
    chk("rmf_count1", 32'(ifa.count), 32'd1);
    tick();
    frame("rmf01", 0, 8'h01, 4, 0, 40);
    chk("rmf_busy_end",  32'(busy_a),    32'd0);
    chk("rmf_count_end", 32'(ifa.count), 32'd0);

    // CLKDIV=1: 0x81 -> 0,1,0,0,0,0,0,0,1,1
    ifb.wr_en = 1'b1; ifb.wr_data = 8'h81;
    tick();
    ifb.wr_en = 1'b0;
    chk("d1_txd0",  32'(txd_b),  32'd1);
    chk("d1_busy0", 32'(busy_b), 32'd0);
    tick();
    frame("d1", 1, 8'h81, 1, 0, 10);
    chk("d1_busy_end", 32'(busy_b), 32'd0);
    chk("d1_txd_end",  32'(txd_b),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
